kbd_fifo: RTL

- Scancode buffer between the PS/2 receiver (`done`/`data` strobe pair) and the CPU keyboard port (0x22).
- Queues bytes so bursts are not lost while the CPU is still in the previous keyboard interrupt.
- Presents the head byte for port reads and a level interrupt request to the IRQ queue logic.
- Pop is driven by the port-0x22 write/ack path.

---
 rtl/kbd_fifo.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/kbd_fifo.sv
// Scancode FIFO between the PS/2 receiver and the CPU keyboard port, with a level IRQ.
// Optional make/break filter in front of the push path: define KBD_FIFO_BREAK_FILTER_EN.
module kbd_fifo #(
    parameter int DEPTH_LOG2       = 4,
    parameter bit IRQ_ON_EMPTY_CLR = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  kb_done,
    input  logic [7:0]            kb_data,
    input  logic                  pop,
    input  logic                  clr,
    output logic [7:0]            head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  irq_req
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  overflow_r;
    logic                  irq_dly_r;
    logic                  empty_s;
    logic                  full_s;
    logic                  push_req_s;
    logic                  do_push_s;
    logic                  do_pop_s;
    logic                  drop_s;

    assign empty_s = (count_r == '0);
    assign full_s  = (count_r == FULL_CNT);

`ifdef KBD_FIFO_BREAK_FILTER_EN
    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_GOT_E0 = 2'd1,
        F_GOT_F0 = 2'd2
    } filt_state_t;

    filt_state_t filt_state_r;
    filt_state_t filt_next_s;
    logic        filt_store_s;

    // Filter state register; advances only on received bytes.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            filt_state_r <= F_IDLE;
        end else if (kb_done) begin
            filt_state_r <= filt_next_s;
        end else begin
            filt_state_r <= filt_state_r;
        end
    end

    // Next filter state and whether the incoming byte is stored (F0 and the byte after it are not).
    always_comb begin
        filt_next_s  = filt_state_r;
        filt_store_s = 1'b0;
        case (filt_state_r)
            F_IDLE: begin
                if (kb_data == 8'hF0) begin
                    filt_next_s  = F_GOT_F0;
                    filt_store_s = 1'b0;
                end else if (kb_data == 8'hE0) begin
                    filt_next_s  = F_GOT_E0;
                    filt_store_s = 1'b1;
                end else begin
                    filt_next_s  = F_IDLE;
                    filt_store_s = 1'b1;
                end
            end
            F_GOT_E0: begin
                if (kb_data == 8'hF0) begin
                    filt_next_s  = F_GOT_F0;
                    filt_store_s = 1'b0;
                end else begin
                    filt_next_s  = F_IDLE;
                    filt_store_s = 1'b1;
                end
            end
            F_GOT_F0: begin
                filt_next_s  = F_IDLE;
                filt_store_s = 1'b0;
            end
            default: begin
                filt_next_s  = F_IDLE;
                filt_store_s = 1'b0;
            end
        endcase
    end

    assign push_req_s = kb_done && filt_store_s;
`else
    assign push_req_s = kb_done;
`endif

    // Accept decisions; a pop on a full FIFO frees the slot for a coincident push.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        drop_s    = 1'b0;
        if (reset || clr) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
            drop_s    = 1'b0;
        end else begin
            do_pop_s  = pop && !empty_s;
            do_push_s = push_req_s && (!full_s || do_pop_s);
            drop_s    = push_req_s && full_s && !do_pop_s;
        end
    end

    // Byte storage; contents are not reset.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= kb_data;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (DEPTH_LOG2 + 1)'(1'b1);
                2'b01:   count_r <= count_r - (DEPTH_LOG2 + 1)'(1'b1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Delayed request used when the IRQ is allowed to lag the last pop by a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_dly_r <= 1'b0;
        end else begin
            irq_dly_r <= !empty_s;
        end
    end

    assign head     = empty_s ? 8'h00 : mem_r[rd_ptr_r];
    assign count    = count_r;
    assign empty    = empty_s;
    assign full     = full_s;
    assign overflow = overflow_r;
    assign irq_req  = IRQ_ON_EMPTY_CLR ? !empty_s : irq_dly_r;

endmodule
